demux1x8_tdm: RTL and testbench



---
 rtl/demux1x8_tdm_if.sv | 42 ++++
 rtl/demux1x8_tdm.sv | 107 ++++++++++
 tb/tb_demux1x8_tdm.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/demux1x8_tdm_if.sv
// Bus bundle for the 1:8 TDM demultiplexer: serial slot input plus eight published lanes.
// Optional frame parity lane appears only when DEMUX_FRAME_PARITY_EN is defined.
interface demux1x8_tdm_if #(
   parameter int WIDTH = 8
);
   // din_valid has no ready: every word presented with din_valid=1 is consumed at that clk edge.
   logic [WIDTH-1:0] din;
   logic             din_valid;
   logic             sync;
   logic [WIDTH-1:0] o0;
   logic [WIDTH-1:0] o1;
   logic [WIDTH-1:0] o2;
   logic [WIDTH-1:0] o3;
   logic [WIDTH-1:0] o4;
   logic [WIDTH-1:0] o5;
   logic [WIDTH-1:0] o6;
   logic [WIDTH-1:0] o7;
   logic [2:0]       slot;
   logic             frame_valid;
   logic             sync_err;
`ifdef DEMUX_FRAME_PARITY_EN
   logic             frame_par;
`endif

   modport master (
`ifdef DEMUX_FRAME_PARITY_EN
      input  frame_par,
`endif
      output din, din_valid, sync,
      input  o0, o1, o2, o3, o4, o5, o6, o7,
      input  slot, frame_valid, sync_err
   );

   modport slave (
`ifdef DEMUX_FRAME_PARITY_EN
      output frame_par,
`endif
      input  din, din_valid, sync,
      output o0, o1, o2, o3, o4, o5, o6, o7,
      output slot, frame_valid, sync_err
   );
endinterface

// File: rtl/demux1x8_tdm.sv
// Time-division 1:8 demultiplexer: collects slots 0..7 into shadows and publishes all lanes at once.
// Optional DEMUX_FRAME_PARITY_EN adds frame_par, the XOR of every published bit.
module demux1x8_tdm #(
   parameter int WIDTH = 8
) (
   input logic            clk,
   input logic            rst,
   demux1x8_tdm_if.slave  bus
);
   localparam int LANES = 8;

   logic [WIDTH-1:0] sh_q [LANES];
   logic [WIDTH-1:0] sh_d [LANES];
   logic [WIDTH-1:0] o_q  [LANES];
   logic [WIDTH-1:0] o_d  [LANES];
   logic [2:0]       slot_q;
   logic [2:0]       slot_d;
   logic             frame_valid_q;
   logic             frame_valid_d;
   logic             sync_err_q;
   logic             sync_err_d;
   logic [2:0]       eff_slot;
   logic             frame_done;
`ifdef DEMUX_FRAME_PARITY_EN
   logic             frame_par_q;
   logic             frame_par_d;
   logic [WIDTH-1:0] par_fold;
`endif

   // sync forces slot 0, so a sync word can never complete a frame.
   always_comb begin
      eff_slot      = bus.sync ? 3'd0 : slot_q;
      frame_done    = bus.din_valid && (eff_slot == 3'd7);
      sh_d          = sh_q;
      o_d           = o_q;
      slot_d        = slot_q;
      frame_valid_d = 1'b0;
      sync_err_d    = 1'b0;

      if (bus.din_valid) begin
         sh_d[eff_slot] = bus.din;
         slot_d         = eff_slot + 3'd1;
         sync_err_d     = bus.sync && (slot_q != 3'd0);
      end

      // Lane 7 takes din directly so the frame is visible one cycle after the slot-7 word.
      if (frame_done) begin
         o_d[0]        = sh_q[0];
         o_d[1]        = sh_q[1];
         o_d[2]        = sh_q[2];
         o_d[3]        = sh_q[3];
         o_d[4]        = sh_q[4];
         o_d[5]        = sh_q[5];
         o_d[6]        = sh_q[6];
         o_d[7]        = bus.din;
         frame_valid_d = 1'b1;
      end
   end

`ifdef DEMUX_FRAME_PARITY_EN
   always_comb begin
      par_fold    = bus.din ^ sh_q[0] ^ sh_q[1] ^ sh_q[2] ^ sh_q[3]
                  ^ sh_q[4] ^ sh_q[5] ^ sh_q[6];
      frame_par_d = frame_done ? (^par_fold) : frame_par_q;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         sh_q          <= '{default: '0};
         o_q           <= '{default: '0};
         slot_q        <= 3'd0;
         frame_valid_q <= 1'b0;
         sync_err_q    <= 1'b0;
      end else begin
         sh_q          <= sh_d;
         o_q           <= o_d;
         slot_q        <= slot_d;
         frame_valid_q <= frame_valid_d;
         sync_err_q    <= sync_err_d;
      end
   end

`ifdef DEMUX_FRAME_PARITY_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_par_q <= 1'b0;
      end else begin
         frame_par_q <= frame_par_d;
      end
   end

   assign bus.frame_par = frame_par_q;
`endif

   assign bus.o0          = o_q[0];
   assign bus.o1          = o_q[1];
   assign bus.o2          = o_q[2];
   assign bus.o3          = o_q[3];
   assign bus.o4          = o_q[4];
   assign bus.o5          = o_q[5];
   assign bus.o6          = o_q[6];
   assign bus.o7          = o_q[7];
   assign bus.slot        = slot_q;
   assign bus.frame_valid = frame_valid_q;
   assign bus.sync_err    = sync_err_q;
endmodule

// File: tb/tb_demux1x8_tdm.sv
// Self-checking bench for demux1x8_tdm: expected frames are queued as stimulus is driven
// and compared whenever frame_valid pulses.
module tb_demux1x8_tdm;
  localparam int W  = 8;
  localparam int FW = 8 * W;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  demux1x8_tdm_if #(.WIDTH(W)) bus ();
  demux1x8_tdm #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;
  logic [FW-1:0] exp_q[$];
  int fv_count = 0;
  int se_count = 0;
  int fv_cyc[$];
  logic [2:0] exp_slot = 3'd0;

  task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [FW-1:0] lanes();
    return {bus.o7, bus.o6, bus.o5, bus.o4, bus.o3, bus.o2, bus.o1, bus.o0};
  endfunction

  function automatic logic [FW-1:0] frame_of(input logic [W-1:0] base);
    logic [FW-1:0] f;
    for (int i = 0; i < 8; i++) f[i*W +: W] = base + W'(i);
    return f;
  endfunction

  // Scoreboard: every frame_valid pulse must match the oldest queued frame.
  always @(negedge clk) begin
    if (bus.frame_valid === 1'b1) begin
      fv_count++;
      fv_cyc.push_back(cyc);
      check("frame_expected", FW'(exp_q.size() != 0), FW'(1));
      if (exp_q.size() != 0) check("frame_lanes", lanes(), exp_q.pop_front());
    end
    if (bus.sync_err === 1'b1) se_count++;
  end

  task automatic send(input logic [W-1:0] w, input logic s);
    bus.din       = w;
    bus.din_valid = 1'b1;
    bus.sync      = s;
    @(posedge clk);
    #1;
    bus.din_valid = 1'b0;
    bus.sync      = 1'b0;
    exp_slot = s ? 3'd1 : exp_slot + 3'd1;
    check("slot", FW'(bus.slot), FW'(exp_slot));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int base;
    int n;
    logic [FW-1:0] prev;

    // Reset with active valid/sync: nothing may leak through.
    rst = 1'b1; bus.din = 8'hFF; bus.din_valid = 1'b1; bus.sync = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check("rst_lanes", lanes(), '0);
      check("rst_slot", FW'(bus.slot), '0);
      check("rst_fv", FW'(bus.frame_valid), '0);
      check("rst_se", FW'(bus.sync_err), '0);
    end
    rst = 1'b0; bus.din_valid = 1'b0; bus.sync = 1'b0;
    idle(1);
    check("post_rst_lanes", lanes(), '0);
    check("post_rst_slot", FW'(bus.slot), '0);
    check("post_rst_fv", FW'(bus.frame_valid), '0);
    check("post_rst_se", FW'(bus.sync_err), '0);

    // Single back-to-back frame.
    exp_q.push_back(frame_of(8'h10));
    for (int i = 0; i < 8; i++) send(8'h10 + W'(i), i == 0);
    check("single_fv", FW'(bus.frame_valid), FW'(1));
    check("single_lanes", lanes(), frame_of(8'h10));
    idle(1);
    check("single_fv_one_cycle", FW'(bus.frame_valid), '0);

    // Gapped frame; sync with slot already 0 must not raise sync_err.
    base = se_count;
    prev = lanes();
    exp_q.push_back(frame_of(8'h10));
    for (int i = 0; i < 8; i++) begin
      send(8'h10 + W'(i), i == 0);
      if (i < 7) begin
        n = $urandom_range(1, 3);
        for (int g = 0; g < n; g++) begin
          idle(1);
          check("gap_slot", FW'(bus.slot), FW'(exp_slot));
          check("gap_hold", lanes(), prev);
        end
      end
    end
    idle(1);
    check("gap_no_sync_err", FW'(se_count - base), '0);

    // Resync mid-frame drops the partial frame.
    exp_q.push_back(frame_of(8'hA0));
    for (int i = 0; i < 8; i++) send(8'hA0 + W'(i), i == 0);
    base = se_count;
    for (int i = 0; i < 3; i++) send(8'hB0 + W'(i), 1'b0);
    send(8'hC0, 1'b1);
    check("resync_se", FW'(bus.sync_err), FW'(1));
    send(8'hC1, 1'b0);
    check("resync_se_pulse", FW'(bus.sync_err), '0);
    check("resync_hold", lanes(), frame_of(8'hA0));
    exp_q.push_back(frame_of(8'hC0));
    for (int i = 2; i < 8; i++) send(8'hC0 + W'(i), 1'b0);
    idle(1);
    check("resync_se_count", FW'(se_count - base), FW'(1));
    check("resync_lanes", lanes(), frame_of(8'hC0));

    // sync landing where slot 7 would be: no completion, restart at slot 0.
    for (int i = 0; i < 7; i++) send(8'hD0 + W'(i), i == 0);
    base = fv_count;
    send(8'hE0, 1'b1);
    check("s7_sync_se", FW'(bus.sync_err), FW'(1));
    idle(1);
    check("s7_no_frame", FW'(fv_count - base), '0);
    exp_q.push_back(frame_of(8'hE0));
    for (int i = 1; i < 8; i++) send(8'hE0 + W'(i), 1'b0);
    idle(1);

    // Continuous stream of three frames.
    base = fv_count;
    exp_q.push_back(frame_of(8'h00));
    exp_q.push_back(frame_of(8'h08));
    exp_q.push_back(frame_of(8'h10));
    for (int i = 0; i < 24; i++) send(W'(i), i == 0);
    idle(1);
    check("stream_count", FW'(fv_count - base), FW'(3));
    n = fv_cyc.size();
    if (n >= 3) begin
      check("stream_gap_a", FW'(fv_cyc[n-1] - fv_cyc[n-2]), FW'(8));
      check("stream_gap_b", FW'(fv_cyc[n-2] - fv_cyc[n-3]), FW'(8));
    end
    check("stream_final", lanes(), frame_of(8'h10));

    // Mid-frame reset discards the partial frame.
    for (int i = 0; i < 5; i++) send(8'h50 + W'(i), i == 0);
    base = fv_count;
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    exp_slot = 3'd0;
    check("midrst_lanes", lanes(), '0);
    check("midrst_slot", FW'(bus.slot), '0);
    exp_q.push_back(FW'(8'h01));
    send(8'h01, 1'b1);
    for (int i = 1; i < 8; i++) send(8'h00, 1'b0);
    idle(1);
    check("midrst_one_frame", FW'(fv_count - base), FW'(1));
    check("midrst_lanes_after", lanes(), FW'(8'h01));
`ifdef DEMUX_FRAME_PARITY_EN
    check("midrst_parity", FW'(bus.frame_par), FW'(1));
`endif

    idle(2);
    check("exp_q_drained", FW'(exp_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
